// File: rtl/clk_div_pkg.sv
`default_nettype none
// ============================================================================
// Module   : clk_div_pkg
// Brief    : Shared defaults and period helper for the multi-channel divider.
// Revision : 1.0  initial release
// ============================================================================
package clk_div_pkg;

    localparam int unsigned C_DEF_PERIOD = 32'd49999999;
    localparam int unsigned C_DEF_HIGH   = 32'd25000000;

    // Period register value for a target output frequency (full period is P+1).
    function automatic int unsigned period_for_hz(input int unsigned clk_hz,
                                                  input int unsigned out_hz);
        return (clk_hz / out_hz) - 32'd1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/multi_clock_divider_if.sv
`default_nettype none
// ============================================================================
// Module   : multi_clock_divider_if
// Brief    : Configuration write bus (valid/ready) for the multi-channel divider.
// Revision : 1.0  initial release
// ============================================================================
interface multi_clock_divider_if #(
    parameter int CHANNELS = 4,
    parameter int CNT_W    = 32
);
    localparam int CH_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

    logic             cfg_valid;
    logic             cfg_ready;
    logic [CH_W-1:0]  cfg_ch;
    logic [CNT_W-1:0] cfg_period;
    logic [CNT_W-1:0] cfg_high;

    modport master (
        output cfg_valid, cfg_ch, cfg_period, cfg_high,
        input  cfg_ready
    );

    modport slave (
        input  cfg_valid, cfg_ch, cfg_period, cfg_high,
        output cfg_ready
    );

endinterface
`default_nettype wire

// File: rtl/clk_div_channel.sv
`default_nettype none
// ============================================================================
// Module   : clk_div_channel
// Brief    : One divider channel: counter, active/shadow config, output flops.
// Revision : 1.0  initial release
// ============================================================================
module clk_div_channel
    import clk_div_pkg::*;
#(
    parameter int               CNT_W      = 32,
    parameter logic [CNT_W-1:0] DEF_PERIOD = CNT_W'(C_DEF_PERIOD),
    parameter logic [CNT_W-1:0] DEF_HIGH   = CNT_W'(C_DEF_HIGH)
) (
    input  wire logic             clk,
    input  wire logic             rst,
    input  wire logic             enable,
    input  wire logic             wr_en,
    input  wire logic [CNT_W-1:0] wr_period,
    input  wire logic [CNT_W-1:0] wr_high,
    output logic                  pend,
    output logic                  div_out,
    output logic                  tick
);

    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] r_period;
    logic [CNT_W-1:0] r_high;
    logic [CNT_W-1:0] r_pend_period;
    logic [CNT_W-1:0] r_pend_high;
    logic             r_pend;
    logic             r_div_out;
    logic             r_tick;

    logic             w_wrap;
    logic             w_apply;

    assign w_wrap  = enable & (r_cnt == r_period);
    // Shadow only lands on a period boundary or while idle, so no runt pulses.
    assign w_apply = r_pend & (~enable | w_wrap);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt         <= '0;
            r_period      <= DEF_PERIOD;
            r_high        <= DEF_HIGH;
            r_pend_period <= '0;
            r_pend_high   <= '0;
            r_pend        <= 1'b0;
            r_div_out     <= 1'b0;
            r_tick        <= 1'b0;
        end else begin
            r_cnt     <= (~enable | w_wrap) ? '0 : r_cnt + CNT_W'(1);
            r_div_out <= enable & (r_cnt < r_high);
            r_tick    <= w_wrap;

            if (w_apply) begin
                r_period <= r_pend_period;
                r_high   <= r_pend_high;
            end

            if (wr_en) begin
                r_pend_period <= wr_period;
                r_pend_high   <= wr_high;
            end

            if (w_apply) begin
                r_pend <= 1'b0;
            end else if (wr_en) begin
                r_pend <= 1'b1;
            end
        end
    end

    assign pend    = r_pend;
    assign div_out = r_div_out;
    assign tick    = r_tick;

endmodule
`default_nettype wire

// File: rtl/multi_clock_divider.sv
`default_nettype none
// ============================================================================
// Module   : multi_clock_divider
// Brief    : N independent programmable clock dividers with shared config bus.
// Revision : 1.0  initial release
// ============================================================================
module multi_clock_divider
    import clk_div_pkg::*;
#(
    parameter int               CHANNELS   = 4,
    parameter int               CNT_W      = 32,
    parameter logic [CNT_W-1:0] DEF_PERIOD = CNT_W'(C_DEF_PERIOD),
    parameter logic [CNT_W-1:0] DEF_HIGH   = CNT_W'(C_DEF_HIGH)
) (
    input  wire logic                clk,
    input  wire logic                rst,
    input  wire logic [CHANNELS-1:0] enable,
    multi_clock_divider_if.slave     cfg,
    output logic      [CHANNELS-1:0] div_out,
    output logic      [CHANNELS-1:0] tick
);

    localparam int CH_W    = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
    localparam int CH_SPAN = 1 << CH_W;

    logic [CHANNELS-1:0] w_pend;
    logic [CH_SPAN-1:0]  w_busy;
    logic                w_accept;

    // Unused channel codes read as not-busy, so out-of-range writes are swallowed.
    always_comb begin
        w_busy                 = '0;
        w_busy[CHANNELS-1:0]   = w_pend;
    end

    assign cfg.cfg_ready = ~w_busy[cfg.cfg_ch];
    assign w_accept      = cfg.cfg_valid & ~w_busy[cfg.cfg_ch];

    generate
        for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
            clk_div_channel #(
                .CNT_W      (CNT_W),
                .DEF_PERIOD (DEF_PERIOD),
                .DEF_HIGH   (DEF_HIGH)
            ) u_channel (
                .clk        (clk),
                .rst        (rst),
                .enable     (enable[i]),
                .wr_en      (w_accept & (cfg.cfg_ch == CH_W'(i))),
                .wr_period  (cfg.cfg_period),
                .wr_high    (cfg.cfg_high),
                .pend       (w_pend[i]),
                .div_out    (div_out[i]),
                .tick       (tick[i])
            );
        end
    endgenerate

endmodule
`default_nettype wire

// File: tb/tb_multi_clock_divider.sv
`default_nettype none
// ============================================================================
// Module   : tb_multi_clock_divider
// Brief    : Randomised + directed bench against a period-start-time model.
// Revision : 1.0  initial release
// ============================================================================
module tb_multi_clock_divider;

    localparam int NCH = 3;
    localparam int CW  = 8;

    logic           clk = 1'b0;
    logic           rst;
    logic [NCH-1:0] enable;
    logic [NCH-1:0] div_out;
    logic [NCH-1:0] tick;

    multi_clock_divider_if #(.CHANNELS(NCH), .CNT_W(CW)) cfg_bus ();

    multi_clock_divider #(
        .CHANNELS   (NCH),
        .CNT_W      (CW),
        .DEF_PERIOD (8'd9),
        .DEF_HIGH   (8'd5)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .enable     (enable),
        .cfg        (cfg_bus),
        .div_out    (div_out),
        .tick       (tick)
    );

    initial forever #5 clk = ~clk;

    int n_total = 0;
    int n_bad   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Model: each channel remembers the cycle its current period began; the
    // output is a pure function of (now - start) against the active P/H.
    int             cyc;
    int             m_t0   [NCH];
    int             m_p    [NCH];
    int             m_h    [NCH];
    int             m_pp   [NCH];
    int             m_ph   [NCH];
    bit             m_pend [NCH];
    logic [NCH-1:0] exp_div;
    logic [NCH-1:0] exp_tick;

    function automatic bit model_ready(input int ch);
        return (ch >= NCH) || !m_pend[ch];
    endfunction

    task automatic model_reset();
        for (int i = 0; i < NCH; i++) begin
            m_t0[i]   = cyc + 1;
            m_p[i]    = 9;
            m_h[i]    = 5;
            m_pend[i] = 1'b0;
        end
        exp_div  = '0;
        exp_tick = '0;
    endtask

    task automatic model_edge();
        bit acc;
        int ph;
        if (rst) begin
            model_reset();
            cyc++;
            return;
        end
        acc = cfg_bus.cfg_valid && model_ready(int'(cfg_bus.cfg_ch));
        for (int i = 0; i < NCH; i++) begin
            ph = cyc - m_t0[i];
            if (!enable[i]) begin
                exp_div[i]  = 1'b0;
                exp_tick[i] = 1'b0;
                m_t0[i]     = cyc + 1;
            end else begin
                exp_div[i]  = (ph < m_h[i]);
                exp_tick[i] = (ph == m_p[i]);
                if (ph == m_p[i]) m_t0[i] = cyc + 1;
            end
            if (m_pend[i] && (!enable[i] || ph == m_p[i])) begin
                m_p[i]    = m_pp[i];
                m_h[i]    = m_ph[i];
                m_pend[i] = 1'b0;
            end
            if (acc && int'(cfg_bus.cfg_ch) == i) begin
                m_pp[i]   = int'(cfg_bus.cfg_period);
                m_ph[i]   = int'(cfg_bus.cfg_high);
                m_pend[i] = 1'b1;
            end
        end
        cyc++;
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        for (int i = 0; i < NCH; i++) begin
            check($sformatf("div_out[%0d]@%0d", i, cyc), div_out[i], exp_div[i]);
            check($sformatf("tick[%0d]@%0d", i, cyc), tick[i], exp_tick[i]);
        end
        check($sformatf("cfg_ready@%0d", cyc), cfg_bus.cfg_ready,
              model_ready(int'(cfg_bus.cfg_ch)));
    endtask

    task automatic cfg_write(input int ch, input int p, input int h, output int waited);
        bit acc;
        cfg_bus.cfg_valid  = 1'b1;
        cfg_bus.cfg_ch     = 2'(ch);
        cfg_bus.cfg_period = CW'(p);
        cfg_bus.cfg_high   = CW'(h);
        waited = 0;
        acc    = 1'b0;
        while (!acc && waited < 64) begin
            acc = model_ready(ch);
            step();
            waited++;
        end
        cfg_bus.cfg_valid = 1'b0;
        if (!acc) check("cfg_write_timeout", 0, 1);
    endtask

    initial begin
        int w;
        int p;
        rst                = 1'b1;
        enable             = '0;
        cfg_bus.cfg_valid  = 1'b0;
        cfg_bus.cfg_ch     = '0;
        cfg_bus.cfg_period = '0;
        cfg_bus.cfg_high   = '0;
        cyc                = 0;
        model_reset();

        repeat (3) step();
        check("reset_ready", cfg_bus.cfg_ready, 1);
        check("reset_div", div_out, 0);

        // Default 9/5 pattern on every channel.
        enable = '1;
        rst    = 1'b0;
        repeat (25) step();

        // Mid-period reprogram of ch0.
        repeat (3) step();
        cfg_write(0, 3, 2, w);
        repeat (20) step();

        // Back-to-back ch1 writes with an independent ch2 write in the stall.
        cfg_write(1, 4, 1, w);
        cfg_bus.cfg_valid  = 1'b1;
        cfg_bus.cfg_ch     = 2'd1;
        cfg_bus.cfg_period = 8'd6;
        cfg_bus.cfg_high   = 8'd3;
        #1;
        check("ch1_stall_ready", cfg_bus.cfg_ready, 0);
        step();
        cfg_write(2, 5, 2, w);
        check("ch2_immediate", w, 1);
        cfg_write(1, 6, 3, w);
        check("ch1_stalled", (w > 1), 1);
        repeat (25) step();

        // Corner duties.
        cfg_write(0, 4, 0, w);
        cfg_write(1, 4, 5, w);
        cfg_write(2, 0, 1, w);
        repeat (30) step();
        check("h0_const_low", div_out[0], 0);
        check("hp1_const_high", div_out[1], 1);
        check("p0_const_high", div_out[2], 1);
        check("p0_tick_every", tick[2], 1);

        // Disable ch0 with a pending config, then restart.
        cfg_write(0, 6, 2, w);
        enable[0] = 1'b0;
        repeat (7) step();
        check("disabled_div", div_out[0], 0);
        enable[0] = 1'b1;
        repeat (20) step();

        // Random traffic including the out-of-range channel code.
        for (int k = 0; k < 400; k++) begin
            cfg_bus.cfg_valid = 1'b0;
            if ($urandom_range(3, 0) == 0) begin
                p                  = $urandom_range(12, 0);
                cfg_bus.cfg_valid  = 1'b1;
                cfg_bus.cfg_ch     = 2'($urandom_range(3, 0));
                cfg_bus.cfg_period = CW'(p);
                cfg_bus.cfg_high   = CW'($urandom_range(p + 2, 0));
            end
            if ($urandom_range(19, 0) == 0) enable[$urandom_range(NCH - 1, 0)] ^= 1'b1;
            step();
        end
        cfg_bus.cfg_valid = 1'b0;

        // Async reset mid-period with ch0 config still pending.
        enable = '1;
        cfg_write(2, 0, 1, w);
        repeat (15) step();
        cfg_write(0, 20, 10, w);
        step();
        rst = 1'b1;
        #1;
        check("async_rst_div", div_out, 0);
        check("async_rst_tick", tick, 0);
        repeat (3) step();
        rst            = 1'b0;
        cfg_bus.cfg_ch = 2'd0;
        #1;
        check("rst_pend_cleared", cfg_bus.cfg_ready, 1);
        repeat (25) step();

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
